// File: rtl/adc_sample_averager.sv
// adc_sample_averager: block-averages 2**LOG2_N ADC samples per channel onto a valid/ready port.
// Define ADC_AVG_PEAK_HOLD_EN to add per-window peak outputs; otherwise the peak_ch* outputs are tied to 0.
module adc_sample_averager #(
   parameter int DATA_W = 16,
   parameter int LOG2_N = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              clear,
   input  logic [DATA_W-1:0] ADC_ValueCH1,
   input  logic [DATA_W-1:0] ADC_ValueCH2,
   input  logic [DATA_W-1:0] ADC_ValueCH3,
   input  logic              sample_updated,
   output logic [DATA_W-1:0] avg_ch1,
   output logic [DATA_W-1:0] avg_ch2,
   output logic [DATA_W-1:0] avg_ch3,
   output logic              avg_valid,
   input  logic              avg_ready,
   output logic              overrun,
   output logic [LOG2_N:0]   window_cnt,
   output logic [DATA_W-1:0] peak_ch1,
   output logic [DATA_W-1:0] peak_ch2,
   output logic [DATA_W-1:0] peak_ch3
);
   localparam int AW = DATA_W + LOG2_N;
   localparam logic [LOG2_N:0] LAST = (LOG2_N+1)'((1 << LOG2_N) - 1);
   logic              prev;
   logic [DATA_W-1:0] x   [3];
   logic [DATA_W-1:0] avg [3];
   logic [AW-1:0]     acc [3];
   logic [AW-1:0]     sum [3];
   logic              rise, take, close, load, idle;
   assign x[0] = ADC_ValueCH1;
   assign x[1] = ADC_ValueCH2;
   assign x[2] = ADC_ValueCH3;
   assign rise  = sample_updated & ~prev;
   assign take  = rise & enable & ~clear;
   assign close = take & (window_cnt == LAST);
   // the result slot is free if empty or being drained in this same cycle
   assign load  = close & (~avg_valid | avg_ready);
   assign idle  = clear | ~enable;
   assign avg_ch1 = avg[0];
   assign avg_ch2 = avg[1];
   assign avg_ch3 = avg[2];
   always_comb begin
      for (int i = 0; i < 3; i++)
         sum[i] = acc[i] + AW'(x[i]);
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev       <= 1'b0;
         window_cnt <= '0;
         avg_valid  <= 1'b0;
         overrun    <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            acc[i] <= '0;
            avg[i] <= '0;
         end
      end else begin
         prev <= sample_updated;
         if (load) avg_valid <= 1'b1;
         else if (avg_ready) avg_valid <= 1'b0;
         if (clear) overrun <= 1'b0;
         else if (close & ~load) overrun <= 1'b1;
         if (idle | close) window_cnt <= '0;
         else if (take) window_cnt <= window_cnt + 1'b1;
         for (int i = 0; i < 3; i++) begin
            if (idle | close) acc[i] <= '0;
            else if (take) acc[i] <= sum[i];
            if (load) avg[i] <= DATA_W'(sum[i] >> LOG2_N);
         end
      end
   end
`ifdef ADC_AVG_PEAK_HOLD_EN
   logic [DATA_W-1:0] rmax [3];
   logic [DATA_W-1:0] mx   [3];
   logic [DATA_W-1:0] pk   [3];
   always_comb begin
      for (int i = 0; i < 3; i++)
         mx[i] = (rmax[i] > x[i]) ? rmax[i] : x[i];
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 3; i++) begin
            rmax[i] <= '0;
            pk[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (idle | close) rmax[i] <= '0;
            else if (take) rmax[i] <= mx[i];
            if (load) pk[i] <= mx[i];
         end
      end
   end
   assign peak_ch1 = pk[0];
   assign peak_ch2 = pk[1];
   assign peak_ch3 = pk[2];
`else
   assign peak_ch1 = '0;
   assign peak_ch2 = '0;
   assign peak_ch3 = '0;
`endif
endmodule

// File: tb/tb_adc_sample_averager.sv
// tb_adc_sample_averager: directed vector table plus hand-written handshake, strobe, clear and reset sequences (LOG2_N=2).
module tb_adc_sample_averager;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b1;
   logic        clear = 1'b0;
   logic [15:0] ch1 = '0, ch2 = '0, ch3 = '0;
   logic        sample_updated = 1'b0;
   logic [15:0] avg_ch1, avg_ch2, avg_ch3;
   logic        avg_valid;
   logic        avg_ready = 1'b1;
   logic        overrun;
   logic [2:0]  window_cnt;
   logic [15:0] peak_ch1, peak_ch2, peak_ch3;
   int total = 0;
   int bad = 0;
`ifdef ADC_AVG_PEAK_HOLD_EN
   localparam bit PK = 1'b1;
`else
   localparam bit PK = 1'b0;
`endif
   always #5 clk = ~clk;
   adc_sample_averager #(.DATA_W(16), .LOG2_N(2)) dut (
      .clk(clk), .rst(rst), .enable(enable), .clear(clear),
      .ADC_ValueCH1(ch1), .ADC_ValueCH2(ch2), .ADC_ValueCH3(ch3),
      .sample_updated(sample_updated),
      .avg_ch1(avg_ch1), .avg_ch2(avg_ch2), .avg_ch3(avg_ch3),
      .avg_valid(avg_valid), .avg_ready(avg_ready), .overrun(overrun),
      .window_cnt(window_cnt),
      .peak_ch1(peak_ch1), .peak_ch2(peak_ch2), .peak_ch3(peak_ch3)
   );
   typedef struct {
      logic [15:0] x1 [4];
      logic [15:0] x2 [4];
      logic [15:0] x3 [4];
      logic [15:0] a1, a2, a3, p1;
   } vec_t;
   vec_t tv [4];
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", n, act, exp);
      end
   endtask
   // one low cycle, then a rising strobe held for 'hold' cycles; ends with the strobe still high
   task automatic smp(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input int hold);
      sample_updated = 1'b0;
      @(negedge clk);
      ch1 = a; ch2 = b; ch3 = c;
      sample_updated = 1'b1;
      @(negedge clk);
      repeat (hold - 1) @(negedge clk);
   endtask
   initial begin
      tv[0] = '{'{16'd10, 16'd20, 16'd30, 16'd40}, '{16'd100, 16'd100, 16'd100, 16'd100},
                '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 16'd25, 16'd100, 16'hFFFF, 16'd40};
      tv[1] = '{'{16'd1, 16'd2, 16'd2, 16'd2}, '{16'd0, 16'd1, 16'd2, 16'd3},
                '{16'd7, 16'd7, 16'd7, 16'd8}, 16'd1, 16'd1, 16'd7, 16'd2};
      tv[2] = '{'{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, '{16'd3, 16'd3, 16'd3, 16'd2},
                '{16'd0, 16'd0, 16'd0, 16'd3}, 16'hFFFF, 16'd2, 16'd0, 16'hFFFF};
      tv[3] = '{'{16'd5, 16'd90, 16'd7, 16'd3}, '{16'd0, 16'd0, 16'd0, 16'd0},
                '{16'd1, 16'd1, 16'd1, 16'd1}, 16'd26, 16'd0, 16'd1, 16'd90};
      @(negedge clk);
      chk("rst_valid", avg_valid, 0);
      chk("rst_avg1", avg_ch1, 0);
      chk("rst_wcnt", window_cnt, 0);
      chk("rst_overrun", overrun, 0);
      rst = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         for (int j = 0; j < 4; j++) begin
            chk($sformatf("v%0d_wcnt%0d", k, j), window_cnt, j);
            chk($sformatf("v%0d_novalid%0d", k, j), avg_valid, 0);
            smp(tv[k].x1[j], tv[k].x2[j], tv[k].x3[j], 1);
         end
         chk($sformatf("v%0d_valid", k), avg_valid, 1);
         chk($sformatf("v%0d_avg1", k), avg_ch1, tv[k].a1);
         chk($sformatf("v%0d_avg2", k), avg_ch2, tv[k].a2);
         chk($sformatf("v%0d_avg3", k), avg_ch3, tv[k].a3);
         chk($sformatf("v%0d_peak1", k), peak_ch1, PK ? tv[k].p1 : 16'd0);
         chk($sformatf("v%0d_wcnt_end", k), window_cnt, 0);
         @(negedge clk);
         chk($sformatf("v%0d_pulse", k), avg_valid, 0);
      end
      // close and accept in the same cycle
      avg_ready = 1'b0;
      for (int j = 0; j < 4; j++) smp(16'd4, 16'd0, 16'd0, 1);
      chk("hold_valid", avg_valid, 1);
      for (int j = 0; j < 3; j++) smp(16'd16, 16'd0, 16'd0, 1);
      chk("hold_avg", avg_ch1, 4);
      sample_updated = 1'b0;
      @(negedge clk);
      ch1 = 16'd16; sample_updated = 1'b1; avg_ready = 1'b1;
      @(negedge clk);
      chk("swap_valid", avg_valid, 1);
      chk("swap_avg", avg_ch1, 16);
      chk("swap_overrun", overrun, 0);
      @(negedge clk);
      chk("swap_drain", avg_valid, 0);
      // second window dropped while the first is still held
      avg_ready = 1'b0;
      for (int j = 0; j < 4; j++) smp(16'd4, 16'd0, 16'd0, 1);
      for (int j = 0; j < 4; j++) smp(16'd8, 16'd0, 16'd0, 1);
      chk("drop_valid", avg_valid, 1);
      chk("drop_avg", avg_ch1, 4);
      chk("drop_overrun", overrun, 1);
      avg_ready = 1'b1;
      @(negedge clk);
      chk("drop_drain", avg_valid, 0);
      chk("drop_sticky", overrun, 1);
      sample_updated = 1'b0; clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("clr_overrun", overrun, 0);
      // wide strobes: 5 cycles each still count as single samples
      avg_ready = 1'b0;
      for (int j = 0; j < 3; j++) smp(16'd12, 16'd0, 16'd0, 5);
      chk("wide_wcnt", window_cnt, 3);
      chk("wide_novalid", avg_valid, 0);
      smp(16'd12, 16'd0, 16'd0, 5);
      chk("wide_valid", avg_valid, 1);
      chk("wide_avg", avg_ch1, 12);
      avg_ready = 1'b1;
      @(negedge clk);
      chk("wide_drain", avg_valid, 0);
      // clear mid-window, including a rise coincident with clear
      smp(16'd100, 16'd0, 16'd0, 1);
      smp(16'd100, 16'd0, 16'd0, 1);
      chk("clr_pre_wcnt", window_cnt, 2);
      sample_updated = 1'b0; clear = 1'b1;
      @(negedge clk);
      chk("clr_wcnt", window_cnt, 0);
      ch1 = 16'd999; sample_updated = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("clr_rise_wcnt", window_cnt, 0);
      for (int j = 0; j < 4; j++) smp(16'd8, 16'd0, 16'd0, 1);
      chk("clr_valid", avg_valid, 1);
      chk("clr_avg", avg_ch1, 8);
      @(negedge clk);
      enable = 1'b0;
      smp(16'd50, 16'd0, 16'd0, 1);
      chk("dis_wcnt", window_cnt, 0);
      chk("dis_valid", avg_valid, 0);
      enable = 1'b1;
      // asynchronous reset mid-window with a held result
      avg_ready = 1'b0;
      for (int j = 0; j < 4; j++) smp(16'd20, 16'd0, 16'd0, 1);
      chk("pre_rst_avg", avg_ch1, 20);
      smp(16'd20, 16'd0, 16'd0, 1);
      smp(16'd20, 16'd0, 16'd0, 1);
      chk("pre_rst_wcnt", window_cnt, 2);
      #2 rst = 1'b0;
      #1;
      chk("arst_avg1", avg_ch1, 0);
      chk("arst_valid", avg_valid, 0);
      chk("arst_wcnt", window_cnt, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
